// File: rtl/epochtv1_bus_master_if.sv
// epochtv1_bus_master_if: host request/stream handshakes and TV-1 CPU bus of the bus master
interface epochtv1_bus_master_if;
  logic        start;
  logic        wr;
  logic [12:0] addr;
  logic [12:0] len;
  logic        busy;
  logic        done;
  logic [7:0]  wd;
  logic        wd_valid;
  logic        wd_ready;
  logic [7:0]  rd;
  logic        rd_valid;
  logic        err;
  logic [12:0] a;
  logic [7:0]  db_o;
  logic        db_oe;
  logic [7:0]  db_i;
  logic        csb;
  logic        rdb;
  logic        wrb;
  modport master (
    input  start, wr, addr, len, wd, wd_valid, db_i,
    output busy, done, wd_ready, rd, rd_valid, err, a, db_o, db_oe, csb, rdb, wrb
  );
  modport slave (
    output start, wr, addr, len, wd, wd_valid, db_i,
    input  busy, done, wd_ready, rd, rd_valid, err, a, db_o, db_oe, csb, rdb, wrb
  );
endinterface

// File: rtl/epochtv1_bus_master.sv
// epochtv1_bus_master: CE-paced block read/write initiator for the Epoch TV-1 CPU bus.
// Defining EPOCHTV1_BM_VERIFY_EN adds a read-back verify cycle after every written byte.
module epochtv1_bus_master #(
  parameter int SETUP_CE  = 1,
  parameter int STROBE_CE = 2,
  parameter int HOLD_CE   = 1
) (
  input logic clk,
  input logic rst,
  input logic ce,
  epochtv1_bus_master_if.master bus
);
`ifdef EPOCHTV1_BM_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, FETCH, SETUP, STROBE, HOLD, NEXT} state_t;
  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n, lim;
  logic [12:0] cur_addr, addr_n, remaining, remaining_n;
  logic [7:0]  wbuf, wbuf_n;
  logic        wr, wr_n, vfy, vfy_n;
  logic        phase_end, last, sample, on_bus, rd_cycle_n;
  assign lim        = state == SETUP ? 4'(SETUP_CE) : state == STROBE ? 4'(STROBE_CE) : 4'(HOLD_CE);
  assign phase_end  = ce && cnt == lim - 4'd1;
  assign last       = remaining == 13'd1;
  assign sample     = state == STROBE && phase_end;
  assign on_bus     = state_n inside {SETUP, STROBE, HOLD};
  // a verify pass reuses the read phases of a write byte
  assign rd_cycle_n = !wr_n || vfy_n;
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    addr_n      = cur_addr;
    remaining_n = remaining;
    wbuf_n      = wbuf;
    wr_n        = wr;
    vfy_n       = vfy;
    if (ce && state inside {SETUP, STROBE, HOLD}) cnt_n = phase_end ? 4'd0 : cnt + 4'd1;
    case (state)
      IDLE: if (bus.start) begin
        wr_n        = bus.wr;
        addr_n      = bus.addr;
        remaining_n = bus.len;
        vfy_n       = 1'b0;
        state_n     = bus.wr ? FETCH : SETUP;
      end
      FETCH: if (bus.wd_valid && bus.wd_ready) begin
        wbuf_n  = bus.wd;
        state_n = SETUP;
      end
      SETUP:  state_n = phase_end ? STROBE : SETUP;
      STROBE: state_n = phase_end ? HOLD : STROBE;
      HOLD: if (phase_end) begin
        vfy_n   = VERIFY && wr && !vfy;
        state_n = vfy_n ? SETUP : NEXT;
      end
      NEXT: begin
        addr_n      = cur_addr + 13'd1;
        remaining_n = remaining - 13'd1;
        vfy_n       = 1'b0;
        state_n     = last ? IDLE : wr ? FETCH : SETUP;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      cur_addr     <= '0;
      remaining    <= '0;
      wbuf         <= '0;
      wr           <= 1'b0;
      vfy          <= 1'b0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.wd_ready <= 1'b0;
      bus.rd       <= '0;
      bus.rd_valid <= 1'b0;
      bus.err      <= 1'b0;
      bus.a        <= '0;
      bus.db_o     <= '0;
      bus.db_oe    <= 1'b0;
      bus.csb      <= 1'b1;
      bus.rdb      <= 1'b1;
      bus.wrb      <= 1'b1;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      cur_addr     <= addr_n;
      remaining    <= remaining_n;
      wbuf         <= wbuf_n;
      wr           <= wr_n;
      vfy          <= vfy_n;
      bus.busy     <= state_n != IDLE;
      bus.done     <= state == NEXT && last;
      bus.wd_ready <= state_n == FETCH;
      bus.rd_valid <= sample && !wr;
      if (sample && !wr) bus.rd <= bus.db_i;
      bus.err      <= VERIFY && !(state == IDLE && bus.start) && (bus.err || (sample && vfy && bus.db_i != wbuf));
      if (state_n == SETUP) bus.a <= addr_n;
      if (state_n == SETUP && !rd_cycle_n) bus.db_o <= wbuf_n;
      bus.csb      <= !on_bus;
      bus.rdb      <= !(state_n == STROBE && rd_cycle_n);
      bus.wrb      <= !(state_n == STROBE && !rd_cycle_n);
      bus.db_oe    <= on_bus && !rd_cycle_n;
    end
  end
endmodule

// File: tb/tb_epochtv1_bus_master.sv
// tb_epochtv1_bus_master: directed bench with a TV-1 memory model and address/read-data scoreboards
module tb_epochtv1_bus_master;
`ifdef EPOCHTV1_BM_VERIFY_EN
  localparam bit VFY = 1'b1;
`else
  localparam bit VFY = 1'b0;
`endif
  localparam int STROBE = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce = 1'b1;
  logic ce_slow = 1'b0;
  logic ce_ph = 1'b0;
  int vecs = 0;
  int errs = 0;
  int done_cnt = 0;
  int wlow = 0;
  int rlow = 0;
  logic wrb_p = 1'b1;
  logic rdb_p = 1'b1;
  logic have;
  logic [12:0] ea;
  logic [7:0] ed;
  logic [7:0] mem [0:8191];
  logic [12:0] addr_q [$];
  logic [7:0] rd_q [$];
  epochtv1_bus_master_if bus();
  epochtv1_bus_master dut (.clk(clk), .rst(rst), .ce(ce), .bus(bus));
  always #5 clk = ~clk;
  // register space $1400-$15FF reads back as zero
  assign bus.db_i = (bus.a >= 13'h1400 && bus.a < 13'h1600) ? 8'h00 : mem[bus.a];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic end_strobe(input string tag, input int w);
    have = addr_q.size() != 0;
    ea = have ? addr_q.pop_front() : 13'h0;
    chk({tag, "_ce_ticks"}, w, STROBE);
    chk({tag, "_addr"}, {have, bus.a}, {1'b1, ea});
  endtask
  always @(negedge clk) begin
    ce_ph = !ce_ph;
    ce = !ce_slow || ce_ph;
    if (rst) begin
      wlow = 0;
      rlow = 0;
      wrb_p = 1'b1;
      rdb_p = 1'b1;
    end else begin
      if (!bus.wrb || !bus.rdb) chk("strobe_excl", {bus.wrb | bus.rdb, bus.csb, bus.db_oe}, {1'b1, 1'b0, !bus.wrb});
      if (bus.wd_ready) chk("fetch_bus_idle", {bus.csb, bus.rdb, bus.wrb, bus.db_oe}, 4'b1110);
      if (!bus.wrb) begin
        mem[bus.a] = bus.db_o;
        if (ce) wlow++;
      end
      if (!bus.rdb && ce) rlow++;
      if (bus.wrb && !wrb_p) begin
        end_strobe("wr_strobe", wlow);
        wlow = 0;
      end
      if (bus.rdb && !rdb_p) begin
        end_strobe("rd_strobe", rlow);
        rlow = 0;
      end
      if (bus.rd_valid) begin
        have = rd_q.size() != 0;
        ed = have ? rd_q.pop_front() : 8'h0;
        chk("rd_data", {have, bus.rd}, {1'b1, ed});
      end
      if (bus.done) begin
        done_cnt++;
        chk("busy_drops_with_done", bus.busy, 0);
      end
      wrb_p = bus.wrb;
      rdb_p = bus.rdb;
    end
  end
  task automatic push_addrs(input logic [12:0] ad, input int n, input int reps);
    for (int i = 0; i < n; i++)
      for (int r = 0; r < reps; r++) addr_q.push_back(ad + 13'(i));
  endtask
  task automatic start_xfer(input logic w, input logic [12:0] ad, input int n);
    @(negedge clk);
    bus.start = 1'b1;
    bus.wr = w;
    bus.addr = ad;
    bus.len = 13'(n);
    @(negedge clk);
    bus.start = 1'b0;
    chk(w ? "wr_accept" : "rd_accept", {bus.busy, bus.csb, bus.wd_ready}, w ? 3'b111 : 3'b100);
  endtask
  task automatic wait_done();
    int d0;
    d0 = done_cnt;
    for (int k = 0; k < 4000 && bus.done !== 1'b1; k++) @(negedge clk);
    chk("done_seen", bus.done, 1);
    repeat (3) @(negedge clk);
    chk("done_once", done_cnt - d0, 1);
    chk("addr_drain", addr_q.size(), 0);
  endtask
  task automatic write_block(input logic [12:0] ad, input int n, input logic [63:0] data, input int gap);
    push_addrs(ad, n, VFY ? 2 : 1);
    start_xfer(1'b1, ad, n);
    for (int i = 0; i < n; i++) begin
      repeat (gap) @(negedge clk);
      bus.wd = data[8*i +: 8];
      bus.wd_valid = 1'b1;
      for (int k = 0; k < 1000 && bus.wd_ready !== 1'b1; k++) @(negedge clk);
      chk("wd_handshake", bus.wd_ready, 1);
      @(negedge clk);
      bus.wd_valid = 1'b0;
    end
    wait_done();
  endtask
  task automatic read_block(input logic [12:0] ad, input int n, input logic [63:0] data);
    for (int i = 0; i < n; i++) rd_q.push_back(data[8*i +: 8]);
    push_addrs(ad, n, 1);
    start_xfer(1'b0, ad, n);
    wait_done();
    chk("rd_drain", rd_q.size(), 0);
  endtask
  initial begin
    int d0;
    bus.start = 1'b0;
    bus.wr = 1'b0;
    bus.addr = '0;
    bus.len = '0;
    bus.wd = '0;
    bus.wd_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_flags", {bus.busy, bus.done, bus.wd_ready, bus.rd_valid, bus.err, bus.db_oe}, 6'b0);
    chk("rst_strobes", {bus.csb, bus.rdb, bus.wrb}, 3'b111);
    chk("rst_a", bus.a, 0);
    chk("rst_db_o", bus.db_o, 0);
    chk("rst_rd", bus.rd, 0);
    rst = 1'b0;
    @(negedge clk);
    write_block(13'h1000, 4, 64'h44332211, 0);
    chk("bgm_1000", mem[13'h1000], 8'h11);
    chk("bgm_1003", mem[13'h1003], 8'h44);
    read_block(13'h1000, 4, 64'h44332211);
    write_block(13'h1FFF, 2, 64'h3CA5, 0);
    chk("wrap_wr_0000", mem[13'h0000], 8'h3C);
    read_block(13'h1FFF, 2, 64'h3CA5);
    write_block(13'h0100, 2, 64'hBEEF, 20);
    chk("slow_wd_0101", mem[13'h0101], 8'hBE);
    ce_slow = 1'b1;
    write_block(13'h0400, 2, 64'h5AC3, 0);
    read_block(13'h0400, 2, 64'h5AC3);
    ce_slow = 1'b0;
    write_block(13'h0200, 3, 64'h030201, 0);
    rd_q.push_back(8'h01);
    rd_q.push_back(8'h02);
    rd_q.push_back(8'h03);
    push_addrs(13'h0200, 3, 1);
    start_xfer(1'b0, 13'h0200, 3);
    repeat (2) @(negedge clk);
    bus.start = 1'b1;
    bus.wr = 1'b1;
    bus.addr = 13'h0800;
    bus.len = 13'd5;
    @(negedge clk);
    bus.start = 1'b0;
    bus.wr = 1'b0;
    chk("busy_ignores_start", {bus.busy, bus.wd_ready}, 2'b10);
    wait_done();
    chk("busy_rd_drain", rd_q.size(), 0);
    push_addrs(13'h0300, 2, VFY ? 2 : 1);
    d0 = done_cnt;
    start_xfer(1'b1, 13'h0300, 8);
    bus.wd = 8'h77;
    bus.wd_valid = 1'b1;
    for (int k = 0; k < 2000 && !(bus.wrb === 1'b0 && bus.a === 13'h0302); k++) @(negedge clk);
    chk("rst_at_strobe3", {bus.wrb, bus.a}, {1'b0, 13'h0302});
    rst = 1'b1;
    bus.wd_valid = 1'b0;
    @(negedge clk);
    chk("rst_bus_release", {bus.csb, bus.wrb, bus.rdb, bus.db_oe, bus.busy, bus.done}, 6'b111000);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("rst_no_done", done_cnt - d0, 0);
    chk("rst_addr_drain", addr_q.size(), 0);
    write_block(13'h1400, 1, 64'h5A, 0);
`ifdef EPOCHTV1_BM_VERIFY_EN
    chk("vfy_err_set", bus.err, 1);
    read_block(13'h0000, 1, 64'h3C);
    chk("vfy_err_cleared", bus.err, 0);
`else
    chk("err_tied_low", bus.err, 0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
